carry_chain_resolver: RTL

- Consumes the propagate/generate vectors produced by a row of compressor counters (e.g. (1,5) counter rows driving LUT6CY PROP/GE pins).
- Resolves them into a binary sum with a carry chain that is time-multiplexed over CHUNK bits per cycle.
- Sits at the tail of a compressor tree, as the final carry-propagate stage, behind a valid/ready handshake.
- Trades latency for area: one CHUNK-wide chain is reused for WIDTH/CHUNK cycles.

---
 rtl/versal_arith_pkg.sv | 27 ++
 rtl/carry_chain_resolver_chunk.sv | 33 +++
 rtl/carry_chain_resolver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/versal_arith_pkg.sv
// ============================================================================
// Module      : versal_arith_pkg
// Description : Shared types and sizing helpers for the carry chain resolver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package versal_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } resolver_state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Index counter is at least one bit wide, even for single-chunk builds.
    function automatic int calc_idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/carry_chain_resolver_chunk.sv
// ============================================================================
// Module      : carry_chunk
// Description : Combinational CHUNK-bit propagate/generate carry chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] prop,
    input  logic [CHUNK-1:0] ge,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    // Mux-style carry (prop selects carry-in, else generate) maps onto the
    // dedicated carry primitives.
    always_comb begin : p_chain
        logic [CHUNK:0] w_c;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            w_c[i+1] = prop[i] ? w_c[i] : ge[i];
        end
        sum  = prop ^ w_c[CHUNK-1:0];
        cout = w_c[CHUNK];
    end

endmodule

`default_nettype wire

// File: rtl/carry_chain_resolver.sv
// ============================================================================
// Module      : carry_chain_resolver
// Description : Time-multiplexed final carry-propagate stage, CHUNK bits/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_chain_resolver
    import versal_arith_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_prop,
    input  logic [WIDTH-1:0] in_ge,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_width(NCHUNK);
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCHUNK - 1);

    if ((CHUNK <= 0) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("carry_chain_resolver: WIDTH must be a positive multiple of CHUNK");
    end

    resolver_state_t  r_state;
    resolver_state_t  w_state_nxt;
    logic [WIDTH-1:0] r_prop;
    logic [WIDTH-1:0] r_ge;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_lo;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;

    assign w_last   = (r_idx == C_LAST_IDX);
    assign w_lo     = 32'(r_idx) * 32'(CHUNK);
    assign w_accept = in_valid & in_ready;

    carry_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .prop (r_prop[w_lo +: CHUNK]),
        .ge   (r_ge[w_lo +: CHUNK]),
        .cin  (r_carry),
        .sum  (w_chunk_sum),
        .cout (w_chunk_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? BUSY : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prop  <= '0;
            r_ge    <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_prop  <= in_prop;
                r_ge    <= in_ge;
                r_carry <= in_cin;
                r_idx   <= '0;
            end else if (r_state == BUSY) begin
                // Unresolved sum bits keep their old contents until their chunk runs.
                r_sum[w_lo +: CHUNK] <= w_chunk_sum;
                r_carry              <= w_chunk_cout;
                r_idx                <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_cout <= w_chunk_cout;
                end
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;

endmodule

`default_nettype wire
